// File: rtl/sr_buf_pkg.sv
// Shared defaults, error-bit indices and flat-address helper for the
// multi-bank search-range buffer.
package sr_buf_pkg;

   localparam int unsigned DEF_PIX_W   = 8;
   localparam int unsigned DEF_ROW_PIX = 11;
   localparam int unsigned DEF_ROWS    = 19;
   localparam int unsigned DEF_NBANKS  = 2;

   localparam int unsigned ERR_WOVF = 0;
   localparam int unsigned ERR_RUDF = 1;
   localparam int unsigned ERR_ROW  = 2;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

   function automatic int unsigned row_addr(input int unsigned bank,
                                            input int unsigned row,
                                            input int unsigned rows = DEF_ROWS);
      return bank * rows + row;
   endfunction

endpackage

// File: rtl/sr_bank_ram.sv
// Simple dual-port row RAM holding all banks back to back; synchronous write,
// registered read with read-enable. The read register resets, the array does not.
module sr_bank_ram #(
   parameter int unsigned DW    = 88,
   parameter int unsigned DEPTH = 38,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Output register holds its value while re is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/sr_bank_buffer.sv
// Multi-bank search-range buffer: loader fills an EMPTY bank while the SAD
// reader consumes a FULL one; banks rotate via fill-complete / release handshakes.
module sr_bank_buffer
   import sr_buf_pkg::*;
#(
   parameter  int unsigned PIX_W   = DEF_PIX_W,
   parameter  int unsigned ROW_PIX = DEF_ROW_PIX,
   parameter  int unsigned ROWS    = DEF_ROWS,
   parameter  int unsigned NBANKS  = DEF_NBANKS,
   localparam int unsigned DW      = PIX_W * ROW_PIX,
   localparam int unsigned RA_W    = $clog2(ROWS),
   localparam int unsigned BA_W    = (NBANKS > 1) ? $clog2(NBANKS) : 1,
   localparam int unsigned CW      = $clog2(NBANKS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [RA_W-1:0] wr_row,
   input  logic [DW-1:0]   wr_data,
   input  logic            wr_last,
   output logic            wr_ready,
   input  logic            rd_en,
   input  logic [RA_W-1:0] rd_row,
   output logic [DW-1:0]   rd_data,
   output logic            rd_valid,
   input  logic            rd_release,
   output logic            rd_bank_ok,
   output logic [CW-1:0]   full_cnt,
   output logic [2:0]      err
);

   localparam int unsigned        DEPTH  = NBANKS * ROWS;
   localparam int unsigned        AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [RA_W:0]      ROWS_L = ROWS[RA_W:0];
   localparam logic [BA_W-1:0]    LAST_B = BA_W'(NBANKS - 1);

   bank_state_e     r_bank_st [NBANKS];
   logic [BA_W-1:0] r_wr_bank;
   logic [BA_W-1:0] r_rd_bank;
   logic [CW-1:0]   r_full_cnt;
   logic [2:0]      r_err;
   logic            r_rd_valid;

   logic            w_wr_ready;
   logic            w_rd_ok;
   logic            w_wr_row_ok;
   logic            w_rd_row_ok;
   logic            w_wr_acc;
   logic            w_wr_done;
   logic            w_rd_acc;
   logic            w_rel;
   logic [2:0]      w_err_set;
   logic [AW-1:0]   w_waddr;
   logic [AW-1:0]   w_raddr;

   function automatic logic [BA_W-1:0] f_next(input logic [BA_W-1:0] p);
      return (p == LAST_B) ? '0 : p + 1'b1;
   endfunction

   assign w_wr_ready  = (r_bank_st[r_wr_bank] == BANK_EMPTY);
   assign w_rd_ok     = (r_bank_st[r_rd_bank] == BANK_FULL);
   assign w_wr_row_ok = ({1'b0, wr_row} < ROWS_L);
   assign w_rd_row_ok = ({1'b0, rd_row} < ROWS_L);

   // A dropped out-of-range write never completes the bank, even with wr_last.
   assign w_wr_acc  = wr_en & w_wr_ready & w_wr_row_ok;
   assign w_wr_done = w_wr_acc & wr_last;
   assign w_rd_acc  = rd_en & w_rd_ok & w_rd_row_ok;
   assign w_rel     = rd_release & w_rd_ok;

   always_comb begin
      w_err_set           = '0;
      w_err_set[ERR_WOVF] = wr_en & ~w_wr_ready;
      w_err_set[ERR_RUDF] = rd_en & ~w_rd_ok;
      w_err_set[ERR_ROW]  = (wr_en & ~w_wr_row_ok) | (rd_en & ~w_rd_row_ok);
   end

   assign w_waddr = AW'(row_addr(32'(r_wr_bank), 32'(wr_row), ROWS));
   assign w_raddr = AW'(row_addr(32'(r_rd_bank), 32'(rd_row), ROWS));

   // wr_bank always points at an EMPTY bank and rd_bank at a FULL one when
   // either handshake fires, so the two updates never hit the same bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned b = 0; b < NBANKS; b++) begin
            r_bank_st[b] <= BANK_EMPTY;
         end
         r_wr_bank  <= '0;
         r_rd_bank  <= '0;
         r_full_cnt <= '0;
         r_err      <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_wr_done) begin
            r_bank_st[r_wr_bank] <= BANK_FULL;
            r_wr_bank            <= f_next(r_wr_bank);
         end
         if (w_rel) begin
            r_bank_st[r_rd_bank] <= BANK_EMPTY;
            r_rd_bank            <= f_next(r_rd_bank);
         end
         case ({w_wr_done, w_rel})
            2'b10:   r_full_cnt <= r_full_cnt + CW'(1);
            2'b01:   r_full_cnt <= r_full_cnt - CW'(1);
            default: r_full_cnt <= r_full_cnt;
         endcase
         r_err      <= r_err | w_err_set;
         r_rd_valid <= w_rd_acc;
      end
   end

   sr_bank_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wr_acc & ~rst),
      .waddr (w_waddr),
      .wdata (wr_data),
      .re    (w_rd_acc & ~rst),
      .raddr (w_raddr),
      .rdata (rd_data)
   );

   assign wr_ready   = w_wr_ready;
   assign rd_bank_ok = w_rd_ok;
   assign full_cnt   = r_full_cnt;
   assign err        = r_err;
   assign rd_valid   = r_rd_valid;

endmodule
